// File: rtl/cv32e40s_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40s_pkg : bit-count operation encoding and adder-tree geometry helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cv32e40s_pkg;

  localparam logic [1:0] c_OP_CPOP = 2'b00;
  localparam logic [1:0] c_OP_CLZ  = 2'b01;
  localparam logic [1:0] c_OP_CTZ  = 2'b10;
  localparam logic [1:0] c_OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    BITCNT_CPOP = c_OP_CPOP,
    BITCNT_CLZ  = c_OP_CLZ,
    BITCNT_CTZ  = c_OP_CTZ,
    BITCNT_RSVD = c_OP_RSVD
  } bitcnt_op_e;

  // Level j of the tree carries WIDTH>>j fields of j+1 bits each.
  function automatic int lvl_bits(input int w, input int j);
    return (w >> j) * (j + 1);
  endfunction

  // Bit offset of level j inside a flat vector holding all levels 0..L.
  function automatic int lvl_off(input int w, input int j);
    int acc;
    acc = 0;
    for (int i = 0; i < j; i++) acc += lvl_bits(w, i);
    return acc;
  endfunction

  // Pipeline stage whose register sits after tree level j, or 0 if none.
  function automatic int stage_at(input int j, input int l, input int n);
    for (int k = 1; k <= n; k++) begin
      if ((k * l + n - 1) / n == j) return k;
    end
    return 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cv32e40s_bitcnt_pipe_if.sv
// ---------------------------------------------------------------------------
// cv32e40s_bitcnt_pipe_if : request/response handshake bundle of the pipe
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cv32e40s_bitcnt_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  import cv32e40s_pkg::*;

  localparam int RW = $clog2(WIDTH) + 1;

  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  bitcnt_op_e       op_i;
  logic [WIDTH-1:0] operand_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [RW-1:0]    result_o;
  logic [TAG_W-1:0] tag_o;

  modport slave (
    input  flush_i, valid_i, op_i, operand_i, tag_i, ready_i,
    output ready_o, valid_o, result_o, tag_o
  );

  modport master (
    output flush_i, valid_i, op_i, operand_i, tag_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o
  );

endinterface

`default_nettype wire

// File: rtl/cv32e40s_popcnt_level.sv
// ---------------------------------------------------------------------------
// cv32e40s_popcnt_level : one combinational adder-tree level, pairwise sums
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cv32e40s_popcnt_level #(
  parameter int FW = 1,
  parameter int NF = 2
) (
  input  logic [NF*FW-1:0]          i_fields,
  output logic [(NF/2)*(FW+1)-1:0]  o_sums
);

  for (genvar p = 0; p < NF / 2; p++) begin : g_pair
    assign o_sums[p*(FW+1) +: FW+1] = {1'b0, i_fields[(2*p)*FW +: FW]}
                                    + {1'b0, i_fields[(2*p+1)*FW +: FW]};
  end

endmodule

`default_nettype wire

// File: rtl/cv32e40s_bitcnt_pipe.sv
// ---------------------------------------------------------------------------
// cv32e40s_bitcnt_pipe : pipelined CPOP/CLZ/CTZ with valid/ready and flush
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cv32e40s_bitcnt_pipe #(
  parameter int WIDTH   = 32,
  parameter int NSTAGES = 2,
  parameter int TAG_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  cv32e40s_bitcnt_pipe_if.slave  bus
);
  import cv32e40s_pkg::*;

  localparam int L   = $clog2(WIDTH);
  localparam int RW  = L + 1;
  localparam int TOT = lvl_off(WIDTH, L + 1);

  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
    $error("cv32e40s_bitcnt_pipe: WIDTH must be 8, 16, 32 or 64");
  end
  if (NSTAGES < 1 || NSTAGES > L) begin : g_bad_stages
    $error("cv32e40s_bitcnt_pipe: NSTAGES must be in 1..log2(WIDTH)");
  end

  // Operand pre-processing: CLZ becomes CTZ of the reversed operand, and
  // CTZ becomes a popcount of the trailing-zero mask.
  logic [WIDTH-1:0] w_rev, w_src, w_tz, w_pre;

  always_comb begin
    w_rev = '0;
    for (int b = 0; b < WIDTH; b++) w_rev[b] = bus.operand_i[WIDTH-1-b];
  end

  always_comb begin
    w_src = (bus.op_i == BITCNT_CLZ) ? w_rev : bus.operand_i;
    w_tz  = ~w_src & (w_src - WIDTH'(1));
    case (bus.op_i)
      BITCNT_CPOP:            w_pre = bus.operand_i;
      BITCNT_CLZ, BITCNT_CTZ: w_pre = w_tz;
      default:                w_pre = '0;
    endcase
  end

  // Stage handshake
  logic [NSTAGES+1:1] w_rdy;
  logic [NSTAGES:1]   w_vin, w_en, r_vld;
  logic [TAG_W-1:0]   w_tin [1:NSTAGES];
  logic [TAG_W-1:0]   r_tag [1:NSTAGES];
  logic               w_acc;

  assign w_rdy[NSTAGES+1] = bus.ready_i;
  assign bus.ready_o      = w_rdy[1] & ~bus.flush_i & ~rst;
  assign w_acc            = bus.valid_i & bus.ready_o;

  for (genvar k = 1; k <= NSTAGES; k++) begin : g_stg
    assign w_rdy[k] = ~r_vld[k] | w_rdy[k+1];
    assign w_en[k]  = w_vin[k] & w_rdy[k];
    if (k == 1) begin : g_head
      assign w_vin[k] = w_acc;
      assign w_tin[k] = bus.tag_i;
    end else begin : g_body
      assign w_vin[k] = r_vld[k-1];
      assign w_tin[k] = r_tag[k-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 1; k <= NSTAGES; k++) begin
      if (rst || bus.flush_i) r_vld[k] <= 1'b0;
      else if (w_rdy[k])      r_vld[k] <= w_vin[k];
      if (w_en[k]) r_tag[k] <= w_tin[k];
    end
  end

  // All tree levels packed back to back; w_fwd is what feeds the next level
  // (registered copy where a stage boundary falls after that level).
  logic [TOT-1:0] w_comb, w_fwd;

  assign w_comb[WIDTH-1:0] = w_pre;
  assign w_fwd[WIDTH-1:0]  = w_comb[WIDTH-1:0];

  for (genvar j = 1; j <= L; j++) begin : g_lvl
    localparam int IOFF  = lvl_off(WIDTH, j - 1);
    localparam int IBITS = lvl_bits(WIDTH, j - 1);
    localparam int OOFF  = lvl_off(WIDTH, j);
    localparam int OBITS = lvl_bits(WIDTH, j);
    localparam int SK    = stage_at(j, L, NSTAGES);

    cv32e40s_popcnt_level #(
      .FW (j),
      .NF (WIDTH >> (j - 1))
    ) u_lvl (
      .i_fields (w_fwd[IOFF +: IBITS]),
      .o_sums   (w_comb[OOFF +: OBITS])
    );

    if (SK != 0) begin : g_reg
      logic [OBITS-1:0] r_q;
      always_ff @(posedge clk) begin
        if (w_en[SK]) r_q <= w_comb[OOFF +: OBITS];
      end
      assign w_fwd[OOFF +: OBITS] = r_q;
    end else begin : g_thru
      assign w_fwd[OOFF +: OBITS] = w_comb[OOFF +: OBITS];
    end
  end

  assign bus.result_o = w_fwd[lvl_off(WIDTH, L) +: RW];
  assign bus.tag_o    = r_tag[NSTAGES];
  assign bus.valid_o  = r_vld[NSTAGES] & ~rst;

endmodule

`default_nettype wire
